reset_sequencer: RTL

- Parametrised power-on and board reset generator for the MIPS150 top level. Replaces the ad-hoc button-pulse counter and lock AND-ing.
- Synchronises N asynchronous lock inputs (PLL, IDELAYCTRL, future DCMs) and the push-button. Debounces the button.
- Holds reset for a programmable time, then releases NUM_STAGES reset domains in order, a fixed gap apart (e.g. memory, then CPU, then UART).
- Records the cause of the last reset and counts reset events for CPU-visible status.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/reset_sync_debounce.sv | 61 ++++++
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and encodings for the board reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ASSERT,
      WAIT_LOCK,
      HOLD,
      RELEASE,
      RUN
   } state_t;

   localparam logic [1:0] CAUSE_POR    = 2'd0;
   localparam logic [1:0] CAUSE_BUTTON = 2'd1;
   localparam logic [1:0] CAUSE_LOCK   = 2'd2;
   localparam logic [1:0] CAUSE_SW     = 2'd3;

   // Counter width able to hold max_val without wrapping.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val) + 1;
   endfunction

endpackage

// File: rtl/reset_sync_debounce.sv
// Multi-flop synchroniser with an optional per-bit debounce filter.
// DEBOUNCE_CYCLES = 0 leaves the synchronised value unfiltered.
module reset_sync_debounce
   import reset_seq_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      end else begin
         sync_ff[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      end
   end

   assign sync_q = sync_ff[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign q = sync_q;
      end else begin : g_debounce
         for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            logic [CW-1:0] cnt;
            logic          db;

            // Any sample agreeing with the filtered value restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  cnt <= '0;
                  db  <= 1'b0;
               end else if (sync_q[b] == db) begin
                  cnt <= '0;
               end else if (cnt == DB_LAST) begin
                  cnt <= '0;
                  db  <= sync_q[b];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            assign q[b] = db;
         end
      end
   endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Board reset generator: waits for locks and a released button, holds,
// then releases NUM_STAGES reset domains in order and logs reset causes.
//
// state     | meaning
// ----------|--------------------------------------------------------
// ASSERT    | all resets held; waiting for the debounced button to be up
// WAIT_LOCK | all resets held; waiting for every lock input to be good
// HOLD      | all resets held for HOLD_CYCLES
// RELEASE   | stages dropping one by one, STAGE_GAP cycles apart
// RUN       | every domain out of reset
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_LOCKS       = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 15,
   parameter int NUM_STAGES      = 3,
   parameter int STAGE_GAP       = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  btn,
   input  logic [NUM_LOCKS-1:0]  lock_in,
   input  logic                  sw_rst_req,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  all_released,
   output logic [1:0]            rst_cause,
   output logic [7:0]            rst_count
);

   localparam int HW  = cnt_width(HOLD_CYCLES);
   localparam int GW  = cnt_width(STAGE_GAP);
   localparam int SIW = cnt_width(NUM_STAGES - 1);

   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0]  GAP_LAST  = GW'(STAGE_GAP - 1);
   localparam logic [SIW-1:0] LAST_IDX  = SIW'(NUM_STAGES - 1);

   state_t               state;
   logic [HW-1:0]        hold_cnt;
   logic [GW-1:0]        gap_cnt;
   logic [SIW-1:0]       stage_idx;
   logic [SIW-1:0]       stage_next;

   logic                 btn_db;
   logic                 btn_db_q;
   logic [NUM_LOCKS-1:0] lock_sync;
   logic                 locks_ok;
   logic                 locks_ok_q;

   logic                 btn_rise;
   logic                 lock_fall;
   logic                 sw_event;
   logic                 armed;
   logic                 any_event;

   reset_sync_debounce #(
      .WIDTH           (1),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn),
      .q     (btn_db)
   );

   reset_sync_debounce #(
      .WIDTH           (NUM_LOCKS),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (0)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (lock_in),
      .q     (lock_sync)
   );

   assign locks_ok   = &lock_sync;
   assign btn_rise   = btn_db & ~btn_db_q;
   assign lock_fall  = ~locks_ok & locks_ok_q;
   assign sw_event   = sw_rst_req & ((state == RELEASE) || (state == RUN));
   assign armed      = (state == HOLD) || (state == RELEASE) || (state == RUN);
   assign any_event  = armed & (btn_rise | lock_fall | sw_event);
   assign stage_next = stage_idx + SIW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ASSERT;
         rst_out      <= '1;
         all_released <= 1'b0;
         rst_cause    <= CAUSE_POR;
         rst_count    <= 8'd0;
         hold_cnt     <= '0;
         gap_cnt      <= '0;
         stage_idx    <= '0;
         btn_db_q     <= 1'b0;
         locks_ok_q   <= 1'b0;
      end else begin
         btn_db_q   <= btn_db;
         locks_ok_q <= locks_ok;

         if (any_event) begin
            // Priority: button, then lock loss, then software request.
            rst_out      <= '1;
            all_released <= 1'b0;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            stage_idx    <= '0;
            if (rst_count != 8'hFF) rst_count <= rst_count + 8'd1;
            if (btn_rise) begin
               state     <= ASSERT;
               rst_cause <= CAUSE_BUTTON;
            end else if (lock_fall) begin
               state     <= WAIT_LOCK;
               rst_cause <= CAUSE_LOCK;
            end else begin
               state     <= ASSERT;
               rst_cause <= CAUSE_SW;
            end
         end else begin
            case (state)
               ASSERT: begin
                  if (!btn_db) state <= WAIT_LOCK;
               end
               WAIT_LOCK: begin
                  if (locks_ok) begin
                     state    <= HOLD;
                     hold_cnt <= '0;
                  end
               end
               HOLD: begin
                  if (hold_cnt == HOLD_LAST) begin
                     rst_out[0] <= 1'b0;
                     stage_idx  <= '0;
                     gap_cnt    <= '0;
                     if (NUM_STAGES == 1) begin
                        state        <= RUN;
                        all_released <= 1'b1;
                     end else begin
                        state <= RELEASE;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + HW'(1);
                  end
               end
               RELEASE: begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt   <= '0;
                     stage_idx <= stage_next;
                     for (int s = 0; s < NUM_STAGES; s++) begin
                        if (SIW'(s) == stage_next) rst_out[s] <= 1'b0;
                     end
                     if (stage_next == LAST_IDX) begin
                        state        <= RUN;
                        all_released <= 1'b1;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end
               end
               RUN: begin
                  rst_out      <= '0;
                  all_released <= 1'b1;
               end
               default: state <= ASSERT;
            endcase
         end
      end
   end

endmodule
